rv32i_if_id_stage: RTL
======================

Name: rv32i_if_id_stage

Overview:
- IF/ID pipeline boundary of the RV32I core.
- Captures fetched PC and instruction from the fetch stage and presents them to decode under a valid/ready handshake.
- A 2-entry skid buffer lets decode stall without losing a fetched beat. Branch/jump redirects flush the stage.
- Also counts decode-stall cycles for performance debug.

Parameters:
XLEN, 32, datapath width of PC and instruction.
NOP_INST, 32'h00000013, instruction driven on INST_OUT when no valid beat is held (addi x0,x0,0).
CNT_W, 16, width of the saturating stall counter.

Ports:
clk  input  1  rising-edge clock.
rst  input  1  asynchronous active-high reset.
PC_IN  input  XLEN  PC of the fetched instruction.
INST_IN  input  XLEN  fetched instruction word.
VALID_IN  input  1  fetch presents a beat this cycle.
READY_OUT  output  1  stage can accept a beat this cycle.
FLUSH_IN  input  1  redirect taken; discard all held and incoming beats.
PC_OUT  output  XLEN  PC of the held beat.
PCPLUS4_OUT  output  XLEN  PC_OUT + 4, modulo 2^XLEN.
INST_OUT  output  XLEN  instruction of the held beat, or NOP_INST.
VALID_OUT  output  1  output beat is valid.
READY_IN  input  1  decode consumes the output beat this cycle.
STALL_CNT_OUT  output  CNT_W  cycles with VALID_OUT=1 and READY_IN=0, saturating.

Behaviour:
- Reset is asynchronous, active-high, using clk and rst. Everything else is synchronous to the rising edge of clk.
- Reset values:
  - state=EMPTY
  - PC_OUT=0, PCPLUS4_OUT=4, INST_OUT=NOP_INST
  - VALID_OUT=0, READY_OUT=1, STALL_CNT_OUT=0
  - skid register contents are don't-care but must be cleared to 0.
- Storage:
  - Output register (OR) drives PC_OUT, INST_OUT and PCPLUS4_OUT. PCPLUS4_OUT is registered with OR, not computed after it.
  - Skid register (SR) holds one overflow beat.
- Handshake terms:
  - accept = VALID_IN & READY_OUT
  - take = VALID_OUT & READY_IN
- READY_OUT = (state != FULL). It is decoded from the state register only and has no combinational path from READY_IN or VALID_IN.
- States:
  - EMPTY: OR invalid, SR empty.
  - ONE: OR valid, SR empty.
  - FULL: OR valid, SR valid.
- Transitions when FLUSH_IN=0:
  - EMPTY: on accept, OR<-in and go to ONE; otherwise stay in EMPTY.
  - ONE, accept & take: OR<-in, stay in ONE.
  - ONE, accept & !take: SR<-in, go to FULL.
  - ONE, !accept & take: go to EMPTY; INST_OUT<-NOP_INST.
  - ONE, neither: hold.
  - FULL, take: OR<-SR, go to ONE.
  - FULL, no take: hold; accept is impossible because READY_OUT=0.
- Latency: a beat accepted in cycle N appears on VALID_OUT in cycle N+1 when the stage was EMPTY, or when it was ONE with take.
- Ordering is strictly FIFO. No beat is dropped or duplicated except by flush.
- VALID_OUT = (state != EMPTY). Whenever VALID_OUT=0, INST_OUT = NOP_INST.
- FLUSH_IN has the highest priority:
  - Next state is EMPTY and VALID_OUT=0 the following cycle.
  - Any beat accepted in the same cycle is discarded.
  - A take in the same cycle still counts as consumed by decode.
  - INST_OUT becomes NOP_INST; PC_OUT and PCPLUS4_OUT hold their last values.
- Stall counter: increments by 1 each cycle with VALID_OUT=1 & READY_IN=0, and saturates at 2^CNT_W-1. It is unaffected by flush and cleared only by reset.
- PC arithmetic wraps: PC_IN=32'hFFFFFFFC gives PCPLUS4_OUT=0.
- Reset asserted mid-operation immediately forces all reset values, regardless of clk.

Test Plan:
- Reset then streaming: VALID_IN=1 with PC 0,4,8 on consecutive cycles, READY_IN=1 → VALID_OUT from cycle 1, PC_OUT=0,4,8 one cycle later, PCPLUS4_OUT=4,8,12, READY_OUT stays 1.
- Backpressure: READY_IN=0 while feeding PC 0x10 and 0x14 → state FULL, READY_OUT=0, PC_OUT holds 0x10. Raise READY_IN → outputs 0x10 then 0x14, READY_OUT returns to 1, no loss.
- Flush: in FULL with PC 0x20/0x24 held, assert FLUSH_IN with VALID_IN=1 PC 0x28 → next cycle VALID_OUT=0, INST_OUT=0x00000013, READY_OUT=1, and 0x28 never appears.
- Stall counter: hold a valid beat with READY_IN=0 for 5 cycles → STALL_CNT_OUT=5. Repeat with CNT_W=2 → saturates at 3.
- Wrap and async reset: PC_IN=0xFFFFFFFC → PCPLUS4_OUT=0x00000000. Then assert rst between clock edges → VALID_OUT=0, INST_OUT=NOP_INST, STALL_CNT_OUT=0 without a clock edge.

Source files
------------

// File: rtl/rv32i_if_id_stage.sv
// rtl/rv32i_if_id_stage.sv - RV32I IF/ID pipeline boundary with 2-entry skid buffer and stall counter
module rv32i_if_id_stage #(
   parameter int               XLEN     = 32,
   parameter logic [XLEN-1:0]  NOP_INST = 32'h00000013,
   parameter int               CNT_W    = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [XLEN-1:0]  PC_IN,
   input  logic [XLEN-1:0]  INST_IN,
   input  logic             VALID_IN,
   output logic             READY_OUT,
   input  logic             FLUSH_IN,
   output logic [XLEN-1:0]  PC_OUT,
   output logic [XLEN-1:0]  PCPLUS4_OUT,
   output logic [XLEN-1:0]  INST_OUT,
   output logic             VALID_OUT,
   input  logic             READY_IN,
   output logic [CNT_W-1:0] STALL_CNT_OUT
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;

   logic [XLEN-1:0]   r_or_pc;
   logic [XLEN-1:0]   r_or_pc4;
   logic [XLEN-1:0]   r_or_inst;
   logic [XLEN-1:0]   r_sr_pc;
   logic [XLEN-1:0]   r_sr_inst;
   logic [CNT_W-1:0]  r_stall_cnt;

   logic              w_accept;
   logic              w_take;
   logic              w_or_load_in;
   logic              w_or_load_sr;
   logic              w_or_clear;
   logic              w_sr_load;

   // Ready and valid come straight from the state register so neither has a
   // combinational path from the downstream or upstream handshake inputs.
   assign READY_OUT     = (r_state != FULL);
   assign VALID_OUT     = (r_state != EMPTY);
   assign w_accept      = VALID_IN & READY_OUT;
   assign w_take        = VALID_OUT & READY_IN;
   assign PC_OUT        = r_or_pc;
   assign PCPLUS4_OUT   = r_or_pc4;
   assign INST_OUT      = r_or_inst;
   assign STALL_CNT_OUT = r_stall_cnt;

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= EMPTY;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state and datapath load decode; flush overrides every other move
   always_comb begin
      w_state_nxt  = r_state;
      w_or_load_in = 1'b0;
      w_or_load_sr = 1'b0;
      w_or_clear   = 1'b0;
      w_sr_load    = 1'b0;
      if (FLUSH_IN) begin
         w_state_nxt = EMPTY;
         w_or_clear  = 1'b1;
      end else begin
         case (r_state)
            EMPTY: begin
               if (w_accept) begin
                  w_or_load_in = 1'b1;
                  w_state_nxt  = ONE;
               end
            end
            ONE: begin
               if (w_accept && w_take) begin
                  w_or_load_in = 1'b1;
               end else if (w_accept) begin
                  w_sr_load   = 1'b1;
                  w_state_nxt = FULL;
               end else if (w_take) begin
                  w_or_clear  = 1'b1;
                  w_state_nxt = EMPTY;
               end
            end
            FULL: begin
               if (w_take) begin
                  w_or_load_sr = 1'b1;
                  w_state_nxt  = ONE;
               end
            end
            default: begin
               w_state_nxt = EMPTY;
               w_or_clear  = 1'b1;
            end
         endcase
      end
   end

   // Output register: PC+4 is computed on the way in so it is a flop output.
   // Emptying only swaps the instruction to NOP; the PCs keep their last value.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_or_pc   <= '0;
         r_or_pc4  <= XLEN'(4);
         r_or_inst <= NOP_INST;
      end else if (w_or_load_in) begin
         r_or_pc   <= PC_IN;
         r_or_pc4  <= PC_IN + XLEN'(4);
         r_or_inst <= INST_IN;
      end else if (w_or_load_sr) begin
         r_or_pc   <= r_sr_pc;
         r_or_pc4  <= r_sr_pc + XLEN'(4);
         r_or_inst <= r_sr_inst;
      end else if (w_or_clear) begin
         r_or_inst <= NOP_INST;
      end
   end

   // Skid register catches the beat that arrives while decode is stalling
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sr_pc   <= '0;
         r_sr_inst <= '0;
      end else if (w_sr_load) begin
         r_sr_pc   <= PC_IN;
         r_sr_inst <= INST_IN;
      end
   end

   // Saturating decode-stall counter, untouched by flush
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_stall_cnt <= '0;
      end else if (VALID_OUT && !READY_IN && (r_stall_cnt != {CNT_W{1'b1}})) begin
         r_stall_cnt <= r_stall_cnt + 1'b1;
      end
   end

endmodule
